// File: rtl/board_link_host.sv
// board_link_host
// Host-side sequencer for the game-of-life system memory's serial port.
// Turns parallel commands into serial memory traffic:
//   op 00 load     : shift CMD_DATA into the memory MSB first under LOAD_MODE
//   op 01 run      : hold RUN_MODE for CMD_COUNT cycles (one generation each)
//   op 10 readback : pulse OUTPUT_MODE for data_size cycles, capture SERIAL_RX,
//                    present the word on RSP_DATA with a valid/ready handshake
//   op 11 reserved : accepted, one busy cycle, nothing else
// Ports:
//   CLK, RESET                      clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY             command handshake
//   CMD_OP, CMD_DATA, CMD_COUNT     command payload, sampled at the accept edge
//   RSP_VALID/RSP_READY, RSP_DATA   readback response handshake and word
//   SERIAL_TX, SERIAL_RX            serial data to / from the memory
//   LOAD_MODE, RUN_MODE, OUTPUT_MODE memory mode controls (mutually exclusive)
//   BUSY                            high whenever the sequencer is not idle
// Every output is a flop loaded from the next-state logic, so each output
// reflects the state the sequencer is in during that cycle.
module board_link_host #(
   parameter int unsigned data_size   = 64,
   parameter int unsigned count_width = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   CMD_VALID,
   output logic                   CMD_READY,
   input  logic [1:0]             CMD_OP,
   input  logic [data_size-1:0]   CMD_DATA,
   input  logic [count_width-1:0] CMD_COUNT,
   output logic                   RSP_VALID,
   input  logic                   RSP_READY,
   output logic [data_size-1:0]   RSP_DATA,
   output logic                   SERIAL_TX,
   input  logic                   SERIAL_RX,
   output logic                   LOAD_MODE,
   output logic                   RUN_MODE,
   output logic                   OUTPUT_MODE,
   output logic                   BUSY
);

   localparam int unsigned BIT_W = $clog2(data_size + 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(data_size);
   localparam logic [BIT_W-1:0] FIRST_RX  = BIT_W'(2);
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_OUT, S_DRAIN, S_RESP
   } state_t;

   state_t                 state, state_n;
   logic [data_size-1:0]   tx_sh, tx_sh_n;
   logic [data_size-1:0]   rx_sh, rx_sh_n;
   logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
   logic [count_width-1:0] gen_cnt, gen_cnt_n;
   logic [count_width-1:0] gen_target, gen_target_n;

   logic                 ready_n, busy_n, load_n, run_n, out_n, tx_n, rsp_valid_n;
   logic [data_size-1:0] rsp_data_n;
   logic                 accept;

   assign accept = CMD_VALID && CMD_READY;

   // State, datapath and output registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= S_IDLE;
         tx_sh       <= '0;
         rx_sh       <= '0;
         bit_cnt     <= '0;
         gen_cnt     <= '0;
         gen_target  <= '0;
         CMD_READY   <= 1'b0;
         BUSY        <= 1'b0;
         LOAD_MODE   <= 1'b0;
         RUN_MODE    <= 1'b0;
         OUTPUT_MODE <= 1'b0;
         SERIAL_TX   <= 1'b0;
         RSP_VALID   <= 1'b0;
         RSP_DATA    <= '0;
      end else begin
         state       <= state_n;
         tx_sh       <= tx_sh_n;
         rx_sh       <= rx_sh_n;
         bit_cnt     <= bit_cnt_n;
         gen_cnt     <= gen_cnt_n;
         gen_target  <= gen_target_n;
         CMD_READY   <= ready_n;
         BUSY        <= busy_n;
         LOAD_MODE   <= load_n;
         RUN_MODE    <= run_n;
         OUTPUT_MODE <= out_n;
         SERIAL_TX   <= tx_n;
         RSP_VALID   <= rsp_valid_n;
         RSP_DATA    <= rsp_data_n;
      end
   end

   // Next state and next output values
   always_comb begin
      state_n      = state;
      tx_sh_n      = tx_sh;
      rx_sh_n      = rx_sh;
      bit_cnt_n    = bit_cnt;
      gen_cnt_n    = gen_cnt;
      gen_target_n = gen_target;
      load_n       = 1'b0;
      run_n        = 1'b0;
      out_n        = 1'b0;
      tx_n         = 1'b0;
      rsp_valid_n  = RSP_VALID;
      rsp_data_n   = RSP_DATA;

      case (state)
         S_IDLE: begin
            if (accept) begin
               case (CMD_OP)
                  OP_LOAD: begin
                     // First bit goes out now; the rest wait in tx_sh, MSB-aligned
                     state_n   = S_LOAD;
                     tx_n      = CMD_DATA[data_size-1];
                     tx_sh_n   = {CMD_DATA[data_size-2:0], 1'b0};
                     load_n    = 1'b1;
                     bit_cnt_n = BIT_W'(1);
                  end
                  OP_RUN: begin
                     // gen_cnt counts generations already issued, including this cycle's
                     state_n      = S_RUN;
                     gen_target_n = CMD_COUNT;
                     if (CMD_COUNT != '0) begin
                        gen_cnt_n = count_width'(1);
                        run_n     = 1'b1;
                     end else begin
                        gen_cnt_n = '0;
                     end
                  end
                  OP_READ: begin
                     state_n   = S_OUT;
                     out_n     = 1'b1;
                     bit_cnt_n = BIT_W'(1);
                     rx_sh_n   = '0;
                  end
                  default: begin
                     // Reserved op reuses the zero-length run path: one busy cycle
                     state_n      = S_RUN;
                     gen_target_n = '0;
                     gen_cnt_n    = '0;
                  end
               endcase
            end
         end

         S_LOAD: begin
            if (bit_cnt == LAST_BIT) begin
               state_n = S_IDLE;
            end else begin
               bit_cnt_n = bit_cnt + BIT_W'(1);
               load_n    = 1'b1;
               tx_n      = tx_sh[data_size-1];
               tx_sh_n   = {tx_sh[data_size-2:0], 1'b0};
            end
         end

         S_RUN: begin
            // Equality compare stops before gen_cnt could ever wrap
            if (gen_cnt == gen_target) begin
               state_n = S_IDLE;
            end else begin
               gen_cnt_n = gen_cnt + count_width'(1);
               run_n     = 1'b1;
            end
         end

         S_OUT: begin
            // Memory output is one cycle late, so the first OUTPUT_MODE cycle has no data
            if (bit_cnt >= FIRST_RX) begin
               rx_sh_n = {rx_sh[data_size-2:0], SERIAL_RX};
            end
            if (bit_cnt == LAST_BIT) begin
               state_n = S_DRAIN;
            end else begin
               bit_cnt_n = bit_cnt + BIT_W'(1);
               out_n     = 1'b1;
            end
         end

         S_DRAIN: begin
            // Last (LSB) sample arrives one cycle after OUTPUT_MODE drops
            rx_sh_n     = {rx_sh[data_size-2:0], SERIAL_RX};
            rsp_data_n  = {rx_sh[data_size-2:0], SERIAL_RX};
            rsp_valid_n = 1'b1;
            state_n     = S_RESP;
         end

         S_RESP: begin
            if (RSP_READY) begin
               rsp_valid_n = 1'b0;
               state_n     = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      ready_n = (state_n == S_IDLE) && !rsp_valid_n;
      busy_n  = (state_n != S_IDLE);
   end

endmodule
